softmax_max_subtract: RTL and testbench
=======================================

# softmax_max_subtract

Streaming max-normalization stage for the softmax datapath. Accepts a vector of VEC_LEN elements over a valid/ready stream, buffers them while tracking the running maximum, then replays every element minus that maximum. The output is always ≤ 0 and feeds the exponent unit. This is the consumer side of max selection: it applies the maximum once it has been found.

## Interface
- BITWIDTH, 16, element width in bits
- VEC_LEN, 8, elements per vector, ≥ 2
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare
- IDX_W, $clog2(VEC_LEN), index width (derived, do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  BITWIDTH  input element
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts
- out_data  out  BITWIDTH+1  signed, buf[i] − max; always ≤ 0
- out_last  out  1  marks element VEC_LEN−1 of the vector
- max_out  out  BITWIDTH  maximum of the current vector
- max_valid  out  1  max_out is valid (high throughout DRAIN)

## Operation
- There are two states, FILL and DRAIN. Reset puts the block in FILL with wr_idx = rd_idx = 0, max_reg = 0 and all buffer entries = 0.
- FILL
  - in_ready = 1 and out_valid = 0.
  - On in_valid && in_ready: buf[wr_idx] ← in_data and wr_idx increments.
  - Max update: when wr_idx == 0, max_reg ← in_data unconditionally. max_reg is never compared against its reset value, so all-negative vectors are correct. Otherwise max_reg ← max(max_reg, in_data).
  - The compare is signed when SIGNED = 1 and unsigned when SIGNED = 0.
  - When the element with wr_idx == VEC_LEN−1 is accepted, wr_idx clears and the state moves to DRAIN.
- DRAIN
  - in_ready = 0, out_valid = 1, max_valid = 1.
  - out_data = ext(buf[rd_idx]) − ext(max_reg), computed at BITWIDTH+1 bits. ext is sign extension when SIGNED = 1 and zero extension when SIGNED = 0. The result cannot overflow.
  - out_last = (rd_idx == VEC_LEN−1).
  - On out_valid && out_ready, rd_idx increments. On the handshake with out_last set, rd_idx clears and the state returns to FILL.
- There is a single buffer, so filling and draining never overlap.
- An element equal to the maximum yields out_data = 0. Ties are allowed and each one yields 0.
- Reset asserted mid-FILL or mid-DRAIN immediately discards the partial or pending vector. No element of it is emitted after reset.

## Timing
- Output reset values: in_ready = 1, out_valid = 0, out_last = 0, max_valid = 0, max_out = 0, out_data = 0.
- in_ready and out_valid decode from state only. Neither depends combinationally on in_valid or out_ready.
- Latency: out_valid rises in the cycle after the last input handshake. At that point max_out already includes the last element.
- Throughput: 1 element/cycle in each phase. A vector occupies at least 2·VEC_LEN cycles.
- In FILL → DRAIN → FILL with out_ready held high, in_ready returns in the cycle after the out_last handshake.
- Backpressure: while out_valid && !out_ready, out_data, out_last and max_out hold stable.
- An in_valid pulse presented during DRAIN is ignored and is not buffered. The upstream must hold it until in_ready is high.
- max_out holds its value from the end of DRAIN until the first acceptance of the next vector.

## Test plan
- Basic signed case (BITWIDTH = 16, VEC_LEN = 4):
  - Stimulus: inputs 3, −7, 12, 5.
  - Required response: max_out = 12; out_data = −9, −19, 0, −7; out_last on the 4th output only; out_valid rises 1 cycle after the 4th input.
- All-negative with ties:
  - Stimulus: inputs −5, −2, −9, −2.
  - Required response: max_out = −2; out_data = −3, 0, −7, 0.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles at rd_idx = 1, with in_valid held high during DRAIN.
  - Required response: out_data holds −19; no element is skipped or duplicated; in_ready stays 0 and no input is accepted.
- Extremes:
  - Stimulus: inputs 0x8000, 0x7FFF, 0x0000, 0x8000.
  - Required response: max = 32767; out_data = −65535, 0, −32767, −65535 (17-bit, no wrap).
- Unsigned (SIGNED = 0):
  - Stimulus: inputs 0xFFFF, 0x0001, 0x8000, 0x0000.
  - Required response: max = 65535; out_data = 0, −65534, −32767, −65535.
- Reset and back-to-back:
  - Stimulus: assert rst asynchronously after 2 inputs, then stream vector 1, 2, 3, 4. Afterwards, stream a second vector 4, 3, 2, 1 with in_valid held high.
  - Required response: outputs are −3, −2, −1, 0. The next vector is accepted starting the cycle after the out_last handshake and produces 0, −1, −2, −3.

Source files
------------

// File: rtl/softmax_max_subtract.sv
//------------------------------------------------------------------------------
// softmax_max_subtract: buffers one vector while tracking its maximum, then
// replays each element minus that maximum.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module softmax_max_subtract #(
  parameter int BITWIDTH = 16,
  parameter int VEC_LEN  = 8,
  parameter bit SIGNED   = 1'b1,
  parameter int IDX_W    = $clog2(VEC_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH:0]   out_data,
  output logic                out_last,
  output logic [BITWIDTH-1:0] max_out,
  output logic                max_valid
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(VEC_LEN - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [BITWIDTH-1:0] max_q, max_d;
  logic [BITWIDTH-1:0] buf_q [VEC_LEN];

  logic                w_in_fire;
  logic                w_out_fire;
  logic [BITWIDTH:0]   w_in_ext;
  logic [BITWIDTH:0]   w_max_ext;
  logic [BITWIDTH:0]   w_rd_ext;

  // One extra bit lets a single signed compare/subtract cover both modes.
  function automatic logic [BITWIDTH:0] ext(input logic [BITWIDTH-1:0] v);
    ext = SIGNED ? {v[BITWIDTH-1], v} : {1'b0, v};
  endfunction

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign max_valid  = (state_q == DRAIN);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  assign w_in_ext  = ext(in_data);
  assign w_max_ext = ext(max_q);
  assign w_rd_ext  = ext(buf_q[rd_idx_q]);

  assign out_data = w_rd_ext - w_max_ext;
  assign out_last = out_valid && (rd_idx_q == C_LAST_IDX);
  assign max_out  = max_q;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    max_d    = max_q;

    if (w_in_fire) begin
      // First element seeds the max so the stale value never wins a compare.
      if ((wr_idx_q == '0) || ($signed(w_in_ext) > $signed(w_max_ext))) begin
        max_d = in_data;
      end
      if (wr_idx_q == C_LAST_IDX) begin
        wr_idx_d = '0;
        state_d  = DRAIN;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    if (w_out_fire) begin
      if (rd_idx_q == C_LAST_IDX) begin
        rd_idx_d = '0;
        state_d  = FILL;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      max_q    <= max_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        buf_q[i] <= '0;
      end
    end else if (w_in_fire) begin
      buf_q[wr_idx_q] <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_softmax_max_subtract.sv
//------------------------------------------------------------------------------
// tb_softmax_max_subtract: directed vectors against signed and unsigned
// 4-element instances of softmax_max_subtract.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_softmax_max_subtract;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;

  logic        s_in_ready, s_out_valid, s_out_last, s_max_valid;
  logic [16:0] s_out_data;
  logic [15:0] s_max_out;
  logic        u_in_ready, u_out_valid, u_out_last, u_max_valid;
  logic [16:0] u_out_data;
  logic [15:0] u_max_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  softmax_max_subtract #(.BITWIDTH(16), .VEC_LEN(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .max_out(s_max_out), .max_valid(s_max_valid)
  );

  softmax_max_subtract #(.BITWIDTH(16), .VEC_LEN(4), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(u_in_ready), .in_data(in_data),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .out_last(u_out_last), .max_out(u_max_out), .max_valid(u_max_valid)
  );

  logic        w_in_ready, w_out_valid, w_out_last, w_max_valid;
  logic [16:0] w_out_data;
  logic [31:0] w_data_obs, w_max_obs;

  assign w_in_ready  = sel ? u_in_ready  : s_in_ready;
  assign w_out_valid = sel ? u_out_valid : s_out_valid;
  assign w_out_last  = sel ? u_out_last  : s_out_last;
  assign w_max_valid = sel ? u_max_valid : s_max_valid;
  assign w_out_data  = sel ? u_out_data  : s_out_data;
  assign w_data_obs  = {{15{w_out_data[16]}}, w_out_data};
  assign w_max_obs   = sel ? {16'h0, u_max_out} : {{16{s_max_out[15]}}, s_max_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_idle(input string tag, input int exp_max);
    chk({tag, "_in_ready"},  {31'b0, w_in_ready},  1);
    chk({tag, "_out_valid"}, {31'b0, w_out_valid}, 0);
    chk({tag, "_max_valid"}, {31'b0, w_max_valid}, 0);
    chk({tag, "_out_last"},  {31'b0, w_out_last},  0);
    chk({tag, "_max_out"},   w_max_obs, exp_max);
  endtask

  task automatic fill(input int v[4], input bit hold, input int exp_max);
    for (int i = 0; i < 4; i++) begin
      chk("fill_in_ready", {31'b0, w_in_ready}, 1);
      in_valid = 1'b1;
      in_data  = 16'(v[i]);
      @(negedge clk);
    end
    in_valid = hold;
    chk("lat_out_valid", {31'b0, w_out_valid}, 1);
    chk("lat_max_valid", {31'b0, w_max_valid}, 1);
    chk("lat_max_out",   w_max_obs, exp_max);
  endtask

  task automatic drain(input int e[4], input int exp_max, input int stall_at);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0063;
        repeat (3) begin
          @(negedge clk);
          chk("stall_data",     w_data_obs, e[i]);
          chk("stall_in_ready", {31'b0, w_in_ready}, 0);
          chk("stall_max_out",  w_max_obs, exp_max);
        end
        in_valid = 1'b0;
      end
      chk("drain_valid", {31'b0, w_out_valid}, 1);
      chk("drain_data",  w_data_obs, e[i]);
      chk("drain_last",  {31'b0, w_out_last}, (i == 3) ? 1 : 0);
      chk("drain_max",   w_max_obs, exp_max);
      chk("drain_in_ready", {31'b0, w_in_ready}, 0);
      out_ready = 1'b1;
      @(negedge clk);
    end
    chk("post_in_ready",  {31'b0, w_in_ready},  1);
    chk("post_out_valid", {31'b0, w_out_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk_idle("rst", 0);
    chk("rst_out_data", w_data_obs, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic signed vector
    fill('{3, -7, 12, 5}, 1'b0, 12);
    drain('{-9, -19, 0, -7}, 12, -1);
    chk_idle("hold_max", 12);

    // All-negative with ties
    fill('{-5, -2, -9, -2}, 1'b0, -2);
    drain('{-3, 0, -7, 0}, -2, -1);

    // Backpressure at rd_idx = 1 with in_valid pulsed during DRAIN
    fill('{3, -7, 12, 5}, 1'b0, 12);
    drain('{-9, -19, 0, -7}, 12, 1);

    // Signed extremes
    fill('{-32768, 32767, 0, -32768}, 1'b0, 32767);
    drain('{-65535, 0, -32767, -65535}, 32767, -1);

    // Unsigned instance
    sel = 1'b1;
    @(negedge clk);
    fill('{65535, 1, 32768, 0}, 1'b0, 65535);
    drain('{0, -65534, -32767, -65535}, 65535, -1);
    sel = 1'b0;
    @(negedge clk);

    // Reset mid-FILL discards partial vector
    in_valid = 1'b1; in_data = 16'd100; @(negedge clk);
    in_data = 16'd200; @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk_idle("arst", 0);
    chk("arst_out_data", w_data_obs, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: next vector waits on in_valid through DRAIN
    fill('{1, 2, 3, 4}, 1'b0, 4);
    in_valid = 1'b1;
    in_data  = 16'd4;
    drain('{-3, -2, -1, 0}, 4, -1);
    chk("b2b_max_hold", w_max_obs, 4);
    chk("b2b_max_valid", {31'b0, w_max_valid}, 0);
    fill('{4, 3, 2, 1}, 1'b0, 4);
    drain('{0, -1, -2, -3}, 4, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
